// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, drives the instruction-memory request and
// registers the returned word for decode. Sequences memory load, fetch and halt.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_INIT | memory load window, startin high, PC held
// S_RUN  | normal fetch with stall and branch/jump redirect
// S_HALT | halt word fetched, everything frozen until reset
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          INIT_CYCLES = 2,
    parameter logic [31:0] HALT_WORD   = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [25:0] jump_index,
    input  logic [31:0] instruction,
    output logic [31:0] address,
    output logic        startin,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
    output logic        valid,
    output logic        halted
);

    localparam int            CW       = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(INIT_CYCLES - 1);

    typedef enum logic [1:0] {S_INIT, S_RUN, S_HALT} state_t;

    state_t          state;
    logic [31:0]     pc;
    logic [CW-1:0]   init_cnt;
    logic [31:0]     next_pc;
    logic [31:0]     jump_target;
    logic            redirect;

    assign address     = pc;
    assign pc_plus4    = pc + 32'd4;
    assign jump_target = {pc_plus4[31:28], jump_index, 2'b00};
    assign redirect    = branch_taken | jump;

    // Branch beats jump; branch targets are forced word-aligned.
    always_comb begin
        next_pc = pc_plus4;
        if (branch_taken)
            next_pc = branch_target & 32'hFFFF_FFFC;
        else if (jump)
            next_pc = jump_target;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_INIT;
            pc        <= RESET_PC;
            init_cnt  <= '0;
            startin   <= 1'b1;
            instr_out <= 32'd0;
            pc_out    <= 32'd0;
            valid     <= 1'b0;
            halted    <= 1'b0;
        end else begin
            case (state)
                S_INIT: begin
                    valid    <= 1'b0;
                    init_cnt <= init_cnt + CW'(1);
                    if (init_cnt == CNT_LAST) begin
                        state   <= S_RUN;
                        startin <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (!stall) begin
                        pc_out <= pc;
                        if (redirect) begin
                            // Word at the current PC is squashed: no delay slot.
                            pc        <= next_pc;
                            instr_out <= 32'd0;
                            valid     <= 1'b0;
                        end else if (instruction == HALT_WORD) begin
                            instr_out <= instruction;
                            valid     <= 1'b1;
                            halted    <= 1'b1;
                            state     <= S_HALT;
                        end else begin
                            pc        <= next_pc;
                            instr_out <= instruction;
                            valid     <= 1'b1;
                        end
                    end
                end
                S_HALT: begin
                    valid <= 1'b0;
                end
                default: begin
                    state <= S_INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: vector table for the main fetch/redirect/halt
// flow, plus hand sequences for reset-in-halt, squashed halt word and reset mid-run.
module tb_instr_fetch_unit;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [25:0] jump_index;
    logic [31:0] instruction;
    logic [31:0] address;
    logic        startin;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        valid;
    logic        halted;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem [32];

    instr_fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .INIT_CYCLES(2),
        .HALT_WORD  (32'hFFFF_FFFF)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .jump         (jump),
        .jump_index   (jump_index),
        .instruction  (instruction),
        .address      (address),
        .startin      (startin),
        .instr_out    (instr_out),
        .pc_out       (pc_out),
        .pc_plus4     (pc_plus4),
        .valid        (valid),
        .halted       (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Asynchronous-read instruction memory, 32 words, address wraps on bits [6:2].
    assign instruction = mem[address[6:2]];

    typedef struct {
        logic        stall;
        logic        br;
        logic [31:0] btgt;
        logic        jmp;
        logic [25:0] jidx;
        logic [31:0] e_addr;
        logic        e_startin;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_pcout;
        logic        e_halted;
    } vec_t;

    vec_t vecs [19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_out(input string tag, input logic [31:0] e_addr, input logic e_startin,
                           input logic e_valid, input logic [31:0] e_instr,
                           input logic [31:0] e_pcout, input logic e_halted);
        chk({tag, ".address"},   address,           e_addr);
        chk({tag, ".pc_plus4"},  pc_plus4,          e_addr + 32'd4);
        chk({tag, ".startin"},   {31'd0, startin},  {31'd0, e_startin});
        chk({tag, ".valid"},     {31'd0, valid},    {31'd0, e_valid});
        chk({tag, ".instr_out"}, instr_out,         e_instr);
        chk({tag, ".pc_out"},    pc_out,            e_pcout);
        chk({tag, ".halted"},    {31'd0, halted},   {31'd0, e_halted});
    endtask

    task automatic drive(input logic s, input logic b, input logic [31:0] bt,
                         input logic j, input logic [25:0] ji);
        stall         = s;
        branch_taken  = b;
        branch_target = bt;
        jump          = j;
        jump_index    = ji;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'hA000_0000 + i;
        mem[5] = 32'hFFFF_FFFF;

        //            stall br  btgt          jmp jidx      addr          st val instr          pcout         hlt
        vecs[0]  = '{1'b0, 1'b1, 32'h80,       1'b0, 26'h0,  32'h0,        1'b1, 1'b0, 32'h0,         32'h0,        1'b0};
        vecs[1]  = '{1'b0, 1'b1, 32'h80,       1'b1, 26'h10, 32'h0,        1'b1, 1'b0, 32'h0,         32'h0,        1'b0};
        vecs[2]  = '{1'b0, 1'b0, 32'h0,        1'b0, 26'h0,  32'h0,        1'b0, 1'b0, 32'h0,         32'h0,        1'b0};
        vecs[3]  = '{1'b0, 1'b0, 32'h0,        1'b0, 26'h0,  32'h4,        1'b0, 1'b1, 32'hA000_0000, 32'h0,        1'b0};
        vecs[4]  = '{1'b1, 1'b0, 32'h0,        1'b0, 26'h0,  32'h8,        1'b0, 1'b1, 32'hA000_0001, 32'h4,        1'b0};
        vecs[5]  = '{1'b1, 1'b1, 32'h41,       1'b0, 26'h0,  32'h8,        1'b0, 1'b1, 32'hA000_0001, 32'h4,        1'b0};
        vecs[6]  = '{1'b1, 1'b0, 32'h0,        1'b0, 26'h0,  32'h8,        1'b0, 1'b1, 32'hA000_0001, 32'h4,        1'b0};
        vecs[7]  = '{1'b0, 1'b0, 32'h0,        1'b0, 26'h0,  32'h8,        1'b0, 1'b1, 32'hA000_0001, 32'h4,        1'b0};
        vecs[8]  = '{1'b0, 1'b1, 32'h41,       1'b0, 26'h0,  32'hC,        1'b0, 1'b1, 32'hA000_0002, 32'h8,        1'b0};
        vecs[9]  = '{1'b0, 1'b1, 32'h23,       1'b1, 26'h10, 32'h40,       1'b0, 1'b0, 32'h0,         32'hC,        1'b0};
        vecs[10] = '{1'b0, 1'b0, 32'h0,        1'b0, 26'h0,  32'h20,       1'b0, 1'b0, 32'h0,         32'h40,       1'b0};
        vecs[11] = '{1'b0, 1'b0, 32'h0,        1'b1, 26'h10, 32'h24,       1'b0, 1'b1, 32'hA000_0008, 32'h20,       1'b0};
        vecs[12] = '{1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 26'h0, 32'h40,       1'b0, 1'b0, 32'h0,         32'h24,       1'b0};
        vecs[13] = '{1'b0, 1'b0, 32'h0,        1'b1, 26'h3,  32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0,        32'h40,       1'b0};
        vecs[14] = '{1'b0, 1'b0, 32'h0,        1'b0, 26'h0,  32'hC,        1'b0, 1'b0, 32'h0,         32'hFFFF_FFFC, 1'b0};
        vecs[15] = '{1'b0, 1'b0, 32'h0,        1'b0, 26'h0,  32'h10,       1'b0, 1'b1, 32'hA000_0003, 32'hC,        1'b0};
        vecs[16] = '{1'b0, 1'b0, 32'h0,        1'b0, 26'h0,  32'h14,       1'b0, 1'b1, 32'hA000_0004, 32'h10,       1'b0};
        vecs[17] = '{1'b0, 1'b1, 32'h40,       1'b0, 26'h0,  32'h14,       1'b0, 1'b1, 32'hFFFF_FFFF, 32'h14,       1'b1};
        vecs[18] = '{1'b0, 1'b0, 32'h0,        1'b0, 26'h0,  32'h14,       1'b0, 1'b0, 32'hFFFF_FFFF, 32'h14,       1'b1};

        drive(1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
        reset = 1'b1;
        tick();
        reset = 1'b0;

        for (int i = 0; i < 19; i++) begin
            chk_out($sformatf("vec%0d", i), vecs[i].e_addr, vecs[i].e_startin, vecs[i].e_valid,
                    vecs[i].e_instr, vecs[i].e_pcout, vecs[i].e_halted);
            drive(vecs[i].stall, vecs[i].br, vecs[i].btgt, vecs[i].jmp, vecs[i].jidx);
            tick();
        end

        // Still frozen in halt with redirect and stall wiggling.
        drive(1'b1, 1'b1, 32'h40, 1'b1, 26'h10);
        tick();
        chk_out("halt_hold", 32'h14, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h14, 1'b1);

        // Reset while halted.
        drive(1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_out("rst_halt", 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        tick();
        tick();
        chk_out("init_done", 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);

        // Jump alone at PC 0.
        drive(1'b0, 1'b0, 32'h0, 1'b1, 26'h10);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
        chk_out("jump_pc0", 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);

        // Walk to the halt word at 0x14 and squash it with a branch.
        drive(1'b0, 1'b1, 32'h0, 1'b0, 26'h0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
        for (int k = 0; k < 5; k++) tick();
        chk_out("at_halt_addr", 32'h14, 1'b0, 1'b1, 32'hA000_0004, 32'h10, 1'b0);
        drive(1'b0, 1'b1, 32'h8, 1'b0, 26'h0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
        chk_out("halt_squashed", 32'h8, 1'b0, 1'b0, 32'h0, 32'h14, 1'b0);
        tick();
        tick();
        chk_out("resume_run", 32'h10, 1'b0, 1'b1, 32'hA000_0003, 32'hC, 1'b0);

        // Reset mid-run at PC 0x10.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_out("rst_run", 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        tick();
        chk_out("rst_run_init2", 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Initiator side of the instruction-memory interface.
- Holds the program counter and drives memory `address`/`startin`.
- Registers the returned `instruction` into a fetch output for the decode stage.
- Sequences init (memory load window), normal fetch with stall and branch/jump redirect, and halt.

Parameters:
- RESET_PC, 32'h0000_0000, PC value after reset.
- INIT_CYCLES, 2, clock cycles `startin` is held high after reset (memory load window); min 1.
- HALT_WORD, 32'hFFFF_FFFF, instruction encoding that stops fetch.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hold PC and fetch outputs this cycle.
- branch_taken  in  1  redirect to branch_target.
- branch_target  in  32  byte address of branch destination.
- jump  in  1  redirect to jump address.
- jump_index  in  26  jump field; target = {pc_plus4[31:28], jump_index, 2'b00}.
- instruction  in  32  word returned by instruction memory for `address`.
- address  out  32  byte address to instruction memory (combinational = PC).
- startin  out  1  memory init/load strobe.
- instr_out  out  32  registered fetched instruction.
- pc_out  out  32  address of instr_out.
- pc_plus4  out  32  PC + 4 (combinational, from current PC).
- valid  out  1  instr_out holds a real instruction this cycle.
- halted  out  1  HALT_WORD has been fetched; fetch stopped.

Behaviour:
- Only reset is asynchronous to nothing: everything is synchronous to clk rising edge; reset has priority over all inputs.
- Reset values:
  - state = INIT, PC = RESET_PC, init counter = 0.
  - startin = 1, instr_out = 0, pc_out = 0, valid = 0, halted = 0.
- address = PC in every state; pc_plus4 = PC + 32'd4, modulo 2^32 (0xFFFF_FFFC wraps to 0).
- States: INIT, RUN, HALT.
- INIT:
  - startin = 1; counter increments each cycle.
  - When counter == INIT_CYCLES-1, next state is RUN; startin is 0 from the first RUN cycle.
  - PC is held; valid = 0; stall/branch/jump are ignored.
- RUN, stall = 1:
  - PC, instr_out, pc_out and valid are held.
  - Redirects asserted during stall are ignored; the requester holds them until stall drops.
- RUN, stall = 0 — next-PC priority (highest first):
  - branch_taken: PC <= {branch_target[31:2], 2'b00}.
  - jump: PC <= {pc_plus4[31:28], jump_index, 2'b00}.
  - else: PC <= pc_plus4.
- RUN, stall = 0 — fetch register update:
  - Redirect (branch_taken or jump) this cycle: the word at the current PC is squashed (valid <= 0, instr_out <= 0, pc_out <= PC). No delay slot.
  - No redirect: instr_out <= instruction, pc_out <= PC, valid <= 1.
- Latency: an instruction appears on instr_out/valid exactly 1 cycle after its address is driven (non-stalled).
- Halt:
  - In RUN with stall = 0, no redirect and instruction == HALT_WORD: latch it as a normal fetch (valid <= 1), go to HALT, set halted <= 1.
  - PC does not advance (stays at the halt address).
- HALT:
  - valid <= 0 after the first HALT cycle; instr_out and pc_out are held.
  - halted = 1; startin = 0; all inputs ignored.
  - Exit is only via reset.
- A HALT_WORD squashed by a redirect does not halt.
- Reset asserted mid-RUN or in HALT returns to INIT next edge; startin re-asserts and memory is reloaded.

Test Plan:
1. Reset with INIT_CYCLES = 2: reset held 1 cycle then released -> startin = 1 for 2 cycles then 0; address = 0x0 throughout INIT; valid = 0.
2. Sequential fetch, memory words W0..W4 at 0x0..0x10 -> address steps 0, 4, 8, 12, 16 one per cycle; instr_out = W0..W4 with pc_out = 0..16 one cycle later; valid = 1 each.
3. Stall = 1 for 3 cycles at PC = 0x8 -> address stays 0x8; instr_out/pc_out frozen at W1/0x4; fetch resumes with W2 at 0x8, no word lost or duplicated.
4. Redirects:
   - branch_taken = 1, branch_target = 0x41 at PC = 0xC -> next address 0x40; the cycle after shows valid = 0.
   - branch_taken and jump (jump_index = 0x10) both asserted -> branch wins.
   - jump alone at PC = 0x0 with jump_index = 0x10 -> address 0x40.
5. HALT_WORD at 0x14 -> instr_out = 0xFFFF_FFFF with valid = 1 for one cycle; halted = 1; address frozen at 0x14; branch_taken ignored.
6. Reset asserted while halted (and separately mid-RUN at PC = 0x10) -> next cycle state INIT, address = RESET_PC, startin = 1, halted = 0, valid = 0.
